// File: rtl/hs_seq_sender_if.sv
// hs_seq_sender_if
//   Four-phase request/acknowledge bundle between the source-domain sender
//   and the receiving-domain checker.
//   Signals:
//     req   - request, driven by the sender (master)
//     data  - WIDTH-bit payload, driven by the sender, stable while req is 1
//     ack   - acknowledge, driven by the receiver (slave), asynchronous to
//             the sender clock
interface hs_seq_sender_if #(
    parameter int WIDTH = 4
);
    logic             req;
    logic             ack;
    logic [WIDTH-1:0] data;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/hs_seq_sender.sv
// hs_seq_sender
//   Source-side stage of the CDC lab. Generates an incrementing WIDTH-bit
//   sequence starting at START and hands each value across a clock-domain
//   boundary with a four-phase req/ack handshake. One transfer can be made
//   to carry data^1 so the downstream checker can be shown to flag a single
//   mismatch and then recover.
//   Ports:
//     clk          - source-domain clock
//     rst_n        - asynchronous active-low reset
//     start        - level enable; transfers run back to back while high
//     inject_error - sampled when req rises; corrupts that transfer's data
//     hs           - master side of the req/ack/data bundle
//     busy         - 1 whenever the FSM is not idle
//     sent_count   - completed handshakes, wraps at 16 bits
module hs_seq_sender #(
    parameter int WIDTH       = 4,
    parameter int START       = 1,
    parameter int GAP         = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   inject_error,
    hs_seq_sender_if.master        hs,
    output logic                   busy,
    output logic [15:0]            sent_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        WAIT = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] START_V  = WIDTH'(START);
    localparam logic [WIDTH-1:0] FLIP_LSB = WIDTH'(1);
    // Counter runs GAP-1 down to 0, giving exactly GAP idle cycles in WAIT.
    localparam logic [7:0]       GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [WIDTH-1:0]       seq_q, seq_d;
    logic [15:0]            sent_q, sent_d;
    logic [7:0]             gap_q, gap_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_s;
    logic                   load_req;

    // ack is asynchronous; only the last synchronizer stage is ever used.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], hs.ack};
    assign ack_s  = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        data_d   = data_q;
        seq_d    = seq_q;
        sent_d   = sent_q;
        gap_d    = gap_q;
        load_req = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) load_req = 1'b1;
            end
            REQ: begin
                // seq advances even for a corrupted transfer, so the stream
                // is back in step on the next handshake.
                if (ack_s) begin
                    state_d = REL;
                    req_d   = 1'b0;
                    seq_d   = seq_q + 1'b1;
                    sent_d  = sent_q + 16'd1;
                end
            end
            REL: begin
                if (!ack_s) begin
                    if (GAP > 0) begin
                        state_d = WAIT;
                        gap_d   = GAP_LOAD;
                    end else if (start) begin
                        load_req = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT: begin
                if (gap_q == 8'd0) begin
                    if (start) load_req = 1'b1;
                    else       state_d  = IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every entry into REQ re-samples inject_error; data changes only here.
        if (load_req) begin
            state_d = REQ;
            req_d   = 1'b1;
            data_d  = inject_error ? (seq_q ^ FLIP_LSB) : seq_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= START_V;
            seq_q   <= START_V;
            sent_q  <= 16'd0;
            gap_q   <= 8'd0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            seq_q   <= seq_d;
            sent_q  <= sent_d;
            gap_q   <= gap_d;
            sync_q  <= sync_d;
        end
    end

    assign hs.req     = req_q;
    assign hs.data    = data_q;
    assign busy       = (state_q != IDLE);
    assign sent_count = sent_q;

endmodule

// File: tb/tb_hs_seq_sender.sv
module tb_hs_seq_sender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic        inj_a, inj_b;
    logic        busy_a, busy_b;
    logic [15:0] sent_a, sent_b;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    hs_seq_sender_if #(.WIDTH(4)) ifs [2] ();

    hs_seq_sender #(.WIDTH(4), .START(1), .GAP(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .inject_error(inj_a),
        .hs(ifs[0]), .busy(busy_a), .sent_count(sent_a)
    );

    hs_seq_sender #(.WIDTH(4), .START(1), .GAP(3), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .inject_error(inj_b),
        .hs(ifs[1]), .busy(busy_b), .sent_count(sent_b)
    );

    // Receiver + checker models: ack follows req 3 cycles after each req
    // edge; each accepted value is logged and compared with an incrementing
    // expectation starting at 1.
    for (genvar g = 0; g < 2; g++) begin : rcv
        logic [1:0] cnt;
        logic [3:0] exp_v;
        logic [3:0] log_v [0:31];
        logic       req_prev;
        logic [3:0] data_prev;
        int         n_rx, n_err, n_unstable, since_fall, last_gap;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ifs[g].ack <= 1'b0;
                cnt        <= 2'd0;
                exp_v      <= 4'd1;
                req_prev   <= 1'b0;
                data_prev  <= 4'd0;
                n_rx       <= 0;
                n_err      <= 0;
                n_unstable <= 0;
                since_fall <= 0;
                last_gap   <= 0;
            end else begin
                req_prev   <= ifs[g].req;
                data_prev  <= ifs[g].data;
                since_fall <= since_fall + 1;
                if (req_prev && ifs[g].req && ifs[g].data != data_prev)
                    n_unstable <= n_unstable + 1;
                if (ifs[g].req && !req_prev)
                    last_gap <= since_fall;
                if (ifs[g].req != ifs[g].ack) begin
                    if (cnt == 2'd2) begin
                        cnt        <= 2'd0;
                        ifs[g].ack <= ifs[g].req;
                        if (ifs[g].req) begin
                            log_v[n_rx[4:0]] <= ifs[g].data;
                            n_rx  <= n_rx + 1;
                            exp_v <= exp_v + 4'd1;
                            if (ifs[g].data != exp_v) n_err <= n_err + 1;
                        end else begin
                            since_fall <= 0;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end else begin
                    cnt <= 2'd0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_sent_a(input int target, input string tag);
        for (int i = 0; i < 2000 && sent_a != 16'(target); i++) @(negedge clk);
        chk(tag, sent_a, target);
    endtask

    task automatic wait_sent_b(input int target, input string tag);
        for (int i = 0; i < 2000 && sent_b != 16'(target); i++) @(negedge clk);
        chk(tag, sent_b, target);
    endtask

    task automatic wait_req_a(input logic val, input string tag);
        for (int i = 0; i < 2000 && ifs[0].req != val; i++) @(negedge clk);
        chk(tag, ifs[0].req, val);
    endtask

    task automatic wait_idle_a(input string tag);
        for (int i = 0; i < 2000 && busy_a; i++) @(negedge clk);
        chk(tag, busy_a, 0);
    endtask

    task automatic wait_idle_b(input string tag);
        for (int i = 0; i < 2000 && busy_b; i++) @(negedge clk);
        chk(tag, busy_b, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        inj_a   = 1'b0;
        inj_b   = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_req", ifs[0].req, 0);
            chk("idle_data", ifs[0].data, 1);
            chk("idle_busy", busy_a, 0);
            chk("idle_sent", sent_a, 0);
        end

        // Basic stream, GAP=0
        start_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("start_req", ifs[0].req, 1);
        chk("start_busy", busy_a, 1);
        wait_sent_a(5, "basic_sent");
        for (int i = 0; i < 5; i++) chk("basic_data", rcv[0].log_v[i], i + 1);
        chk("basic_err", rcv[0].n_err, 0);
        chk("gap0_cycles", rcv[0].last_gap, 3);

        // Wrap
        wait_sent_a(20, "wrap_sent");
        chk("wrap_d13", rcv[0].log_v[13], 14);
        chk("wrap_d14", rcv[0].log_v[14], 15);
        chk("wrap_d15", rcv[0].log_v[15], 0);
        chk("wrap_d16", rcv[0].log_v[16], 1);
        chk("wrap_d19", rcv[0].log_v[19], 4);
        chk("wrap_err", rcv[0].n_err, 0);
        chk("stable_a", rcv[0].n_unstable, 0);

        // Stop mid-transfer
        wait_req_a(1'b1, "stop_in_req");
        start_a = 1'b0;
        wait_idle_a("stop_idle");
        chk("stop_sent", sent_a, 21);
        chk("stop_req", ifs[0].req, 0);
        chk("stop_data", ifs[0].data, 5);
        repeat (10) @(negedge clk);
        chk("stop_req_hold", ifs[0].req, 0);
        chk("stop_busy_hold", busy_a, 0);
        chk("stop_sent_hold", sent_a, 21);
        chk("stop_last", rcv[0].log_v[20], 5);

        // GAP=3 instance
        start_b = 1'b1;
        wait_sent_b(3, "gap3_sent");
        chk("gap3_cycles", rcv[1].last_gap, 6);
        chk("gap3_d0", rcv[1].log_v[0], 1);
        chk("gap3_d1", rcv[1].log_v[1], 2);
        chk("gap3_d2", rcv[1].log_v[2], 3);
        start_b = 1'b0;
        wait_idle_b("gap3_idle");
        chk("stable_b", rcv[1].n_unstable, 0);

        // Error injection at the 3rd req
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        wait_sent_a(2, "inj_pre");
        inj_a = 1'b1;
        wait_req_a(1'b1, "inj_req3");
        chk("inj_data3", ifs[0].data, 2);
        inj_a = 1'b0;
        wait_sent_a(5, "inj_sent");
        chk("inj_d0", rcv[0].log_v[0], 1);
        chk("inj_d2", rcv[0].log_v[2], 2);
        chk("inj_d3", rcv[0].log_v[3], 4);
        chk("inj_d4", rcv[0].log_v[4], 5);
        chk("inj_err", rcv[0].n_err, 1);
        start_a = 1'b0;
        wait_idle_a("inj_idle");

        // Async reset mid-handshake
        start_a = 1'b1;
        wait_req_a(1'b1, "ares_req");
        #2 rst_n = 1'b0;
        #1;
        chk("ares_req", ifs[0].req, 0);
        chk("ares_busy", busy_a, 0);
        chk("ares_data", ifs[0].data, 1);
        chk("ares_sent", sent_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sent_a(1, "ares_sent1");
        chk("ares_first", rcv[0].log_v[0], 1);
        chk("ares_err", rcv[0].n_err, 0);
        start_a = 1'b0;
        wait_idle_a("ares_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hs_seq_sender.md
# hs_seq_sender

Source-side stage for the CDC lab: generates an incrementing WIDTH-bit test sequence and delivers each value across a clock-domain boundary with a four-phase req/ack handshake. Sits directly upstream of the receiving-domain checker, which compares each received value against its own incrementing expectation, starting at 1. Optional single-transfer corruption lets the bench prove that the checker flags a mismatch and then recovers.

## Interface
- WIDTH, 4: data width; the sequence wraps modulo 2^WIDTH.
- START, 1: first value sent after reset.
- GAP, 0: idle cycles inserted between the end of one handshake and the next req; 0..255.
- SYNC_STAGES, 2: flops in the ack synchronizer; must be at least 2.
- clk  in  1  sole clock, source domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level enable; while high, transfers run back to back, separated by GAP.
- inject_error  in  1  sampled when req rises; if 1, that transfer carries the corrupted value data^1.
- ack  in  1  acknowledge from the receiving domain; asynchronous to clk.
- req  out  1  request to the receiving domain; registered.
- data  out  WIDTH  value being transferred; registered and stable whenever req is 1.
- busy  out  1  1 in any state other than IDLE.
- sent_count  out  16  number of completed handshakes; wraps.

## Operation
- ack passes through a SYNC_STAGES-flop synchronizer to give ack_s. Only ack_s is used internally.
- Internal register seq holds the next sequence value. It resets to START.
- FSM states are IDLE, REQ, REL and WAIT. Transitions are evaluated on each rising clk edge:
  - IDLE: if start, go to REQ. Drive req=1 and data = inject_error ? seq^1 : seq.
  - REQ: hold req and data. When ack_s=1, go to REL: drive req=0, set seq <= seq+1 (mod 2^WIDTH), increment sent_count.
  - REL: when ack_s=0, the handshake is complete.
    - If GAP>0, go to WAIT and load the gap counter with GAP-1.
    - Else if start, go to REQ.
    - Else go to IDLE.
  - WAIT: decrement the gap counter. At 0, go to REQ if start, else go to IDLE.
- Entering REQ from any state always re-samples inject_error and loads data from seq.
- Corruption affects only the presented value; seq advances normally. The receiver sees exactly one mismatch, then correct values resume.
- Deasserting start mid-transfer does not abort it. The current handshake completes fully, then the FSM goes to IDLE or WAIT.
- data may change only when req rises. It holds through REL, WAIT and IDLE.
- seq wrap: 2^WIDTH-1 is followed by 0; no special handling.
- If ack is already high in IDLE (protocol violation), the FSM still waits in REQ until ack_s is 1. The resulting immediate REL is permitted; no error flag.

## Timing
- Reset values (asynchronous, on rst_n low):
  - req=0, data=START, busy=0, sent_count=0.
  - seq=START, state IDLE, all synchronizer flops 0.
- Reset asserted mid-handshake drops req immediately, without waiting for a clock edge.
- start high in cycle n (FSM in IDLE) gives req=1 and busy=1 from cycle n+1.
- ack rising gives ack_s high SYNC_STAGES cycles later. req falls on the following edge, with seq and sent_count updated on that same edge.
- ack falling gives ack_s low SYNC_STAGES cycles later, after which the FSM leaves REL.
- With GAP=0 and start held, req rises on the same edge that REL exits.
- Minimum period per transfer (GAP=0, instant-ack receiver): 2*(SYNC_STAGES+1) source cycles, plus receiver-side latency.
- busy falls on the edge that enters IDLE.

## Test plan
- Reset and idle: rst_n low, then high, with start=0 for 20 cycles → req=0, data=1, busy=0, sent_count=0 throughout.
- Basic stream: start=1, receiver model acks 3 cycles after req rises and drops ack 3 cycles after req falls → data sequence 1,2,3,4,5; data stable while req=1; sent_count=5 after 5 handshakes; the checker reports no failure.
- Wrap: 20 transfers with WIDTH=4 → data goes …14,15,0,1,2,3,4; sent_count=20.
- Error injection: inject_error=1 only at the 3rd req → 3rd data=2 (3^1); 4th data=4; sent_count unaffected; the checker flags exactly one failure.
- Stop mid-transfer and GAP=3: drop start while in REQ → handshake completes, req stays 0, busy=0 after REL. Re-enable with GAP=3 → between REL exit and the next req rise there are exactly 3 cycles.
- Async reset mid-handshake: pull rst_n low while req=1 → req=0 before the next clk edge. After release: data=1, sent_count=0, and the next transfer sends 1.
